// File: rtl/sync_sp_ram_pkg.sv
// Shared types and helpers for the byte-enable single-port RAM and its output pipeline.
package sync_sp_ram_pkg;

   typedef enum logic {
      INIT,
      READY
   } state_e;

   function automatic int byteCount(input int dataWidth);
      return dataWidth / 8;
   endfunction

   // Even parity: the stored bit makes the total number of ones in byte+bit even.
   function automatic logic evenParity(input logic [7:0] byteVal);
      return ^byteVal;
   endfunction

endpackage

// File: rtl/sync_ram_out_pipe.sv
// N-stage output register for read results; N=0 is a pure pass-through.
module sync_ram_out_pipe #(
   parameter int N = 0,
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   input  logic         addrErr_i,
   input  logic         parErr_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         addrErr_o,
   output logic         parErr_o
);

   generate
      if (N == 0) begin : gPass
         logic unusedClkRst;
         assign unusedClkRst = clk_i ^ rst_i;
         assign valid_o      = valid_i;
         assign data_o       = data_i;
         assign addrErr_o    = addrErr_i;
         assign parErr_o     = parErr_i;
      end else begin : gRegs
         logic [N-1:0] valid_q;
         logic [N-1:0] addrErr_q;
         logic [N-1:0] parErr_q;
         logic [W-1:0] data_q [N];

         // Payload only loads behind a valid so the last read result is held.
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               valid_q   <= '0;
               addrErr_q <= '0;
               parErr_q  <= '0;
               for (int s = 0; s < N; s++) data_q[s] <= '0;
            end else begin
               valid_q[0] <= valid_i;
               if (valid_i) begin
                  data_q[0]    <= data_i;
                  addrErr_q[0] <= addrErr_i;
                  parErr_q[0]  <= parErr_i;
               end
               for (int s = 1; s < N; s++) begin
                  valid_q[s] <= valid_q[s-1];
                  if (valid_q[s-1]) begin
                     data_q[s]    <= data_q[s-1];
                     addrErr_q[s] <= addrErr_q[s-1];
                     parErr_q[s]  <= parErr_q[s-1];
                  end
               end
            end
         end

         assign valid_o   = valid_q[N-1];
         assign data_o    = data_q[N-1];
         assign addrErr_o = addrErr_q[N-1];
         assign parErr_o  = parErr_q[N-1];
      end
   endgenerate

endmodule

// File: rtl/sync_sp_ram_be_pipe.sv
// Single-port RAM with byte enables, hardware clear sweep and pipelined valid-qualified reads.
// Optional per-byte parity storage/checking is enabled by defining SYNC_SP_RAM_PARITY_EN.
module sync_sp_ram_be_pipe
   import sync_sp_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_DEPTH = 1024,
   parameter int DATA_WIDTH = 32,
   parameter int OUT_REGS   = 0,
   parameter int INIT_SWEEP = 1
) (
   input  logic                    Clk_CI,
   input  logic                    Rst_RI,
   input  logic                    Req_SI,
   input  logic                    WrEn_SI,
   input  logic [ADDR_WIDTH-1:0]   Addr_DI,
   input  logic [DATA_WIDTH/8-1:0] ByteEn_DI,
   input  logic [DATA_WIDTH-1:0]   WrData_DI,
   output logic                    Gnt_SO,
   output logic                    RdValid_SO,
   output logic [DATA_WIDTH-1:0]   RdData_DO,
   output logic                    AddrErr_SO,
   output logic                    ParErr_SO
);

   localparam int NB    = byteCount(DATA_WIDTH);
   localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

   generate
      if (DATA_WIDTH % 8 != 0) begin : gErrWidth
         $error("DATA_WIDTH must be a multiple of 8");
      end
      if (64'(DATA_DEPTH) > (64'(1) << ADDR_WIDTH)) begin : gErrDepth
         $error("DATA_DEPTH exceeds the address space");
      end
      if (OUT_REGS < 0 || OUT_REGS > 3) begin : gErrRegs
         $error("OUT_REGS must be in 0..3");
      end
   endgenerate

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   mem_q [DATA_DEPTH];

   logic                    gnt, inRange, wrEn, rdEn;
   logic [IDX_W-1:0]        idx;

   logic                    rdValid_q, rdAddrErr_q, wrAddrErr_q;
   logic [DATA_WIDTH-1:0]   rdData_q;
   logic                    rdParErr;

   logic                    pipeValid, pipeAddrErr, pipeParErr;
   logic [DATA_WIDTH-1:0]   pipeData;

   assign gnt     = Req_SI && (state_q == READY);
   assign inRange = {1'b0, Addr_DI} < (ADDR_WIDTH+1)'(DATA_DEPTH);
   assign idx     = Addr_DI[IDX_W-1:0];
   assign wrEn    = gnt && WrEn_SI && inRange;
   assign rdEn    = gnt && !WrEn_SI;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == IDX_W'(DATA_DEPTH - 1)) state_d = READY;
      end
   end

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         state_q <= (INIT_SWEEP != 0) ? INIT : READY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Array has no reset; nothing is written on a reset edge so a restart is clean.
   always_ff @(posedge Clk_CI) begin
      if (!Rst_RI) begin
         if (state_q == INIT) begin
            mem_q[cnt_q] <= '0;
         end else if (wrEn) begin
            for (int b = 0; b < NB; b++) begin
               if (ByteEn_DI[b]) mem_q[idx][8*b +: 8] <= WrData_DI[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         rdValid_q   <= 1'b0;
         rdAddrErr_q <= 1'b0;
         wrAddrErr_q <= 1'b0;
         rdData_q    <= '0;
      end else begin
         rdValid_q   <= rdEn;
         wrAddrErr_q <= gnt && WrEn_SI && !inRange;
         if (rdEn) begin
            rdData_q    <= inRange ? mem_q[idx] : '0;
            rdAddrErr_q <= !inRange;
         end
      end
   end

`ifdef SYNC_SP_RAM_PARITY_EN
   logic [NB-1:0] par_q [DATA_DEPTH];
   logic [NB-1:0] rdPar_q;

   always_ff @(posedge Clk_CI) begin
      if (!Rst_RI) begin
         if (state_q == INIT) begin
            par_q[cnt_q] <= '0;
         end else if (wrEn) begin
            for (int b = 0; b < NB; b++) begin
               if (ByteEn_DI[b]) par_q[idx][b] <= evenParity(WrData_DI[8*b +: 8]);
            end
         end
      end
   end

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         rdPar_q <= '0;
      end else if (rdEn) begin
         rdPar_q <= inRange ? par_q[idx] : '0;
      end
   end

   always_comb begin
      rdParErr = 1'b0;
      for (int b = 0; b < NB; b++) begin
         if (evenParity(rdData_q[8*b +: 8]) != rdPar_q[b]) rdParErr = 1'b1;
      end
   end
`else
   assign rdParErr = 1'b0;
`endif

   sync_ram_out_pipe #(
      .N (OUT_REGS),
      .W (DATA_WIDTH)
   ) i_out_pipe (
      .clk_i     (Clk_CI),
      .rst_i     (Rst_RI),
      .valid_i   (rdValid_q),
      .data_i    (rdData_q),
      .addrErr_i (rdAddrErr_q),
      .parErr_i  (rdParErr),
      .valid_o   (pipeValid),
      .data_o    (pipeData),
      .addrErr_o (pipeAddrErr),
      .parErr_o  (pipeParErr)
   );

   // Error flags are held with the data, so qualify them with the valid pulse.
   assign Gnt_SO     = gnt;
   assign RdValid_SO = pipeValid;
   assign RdData_DO  = pipeData;
   assign AddrErr_SO = (pipeValid && pipeAddrErr) || wrAddrErr_q;
   assign ParErr_SO  = pipeValid && pipeParErr;

endmodule

// File: tb/tb_sync_sp_ram_be_pipe.sv
// Directed bench for sync_sp_ram_be_pipe: 16 words, 5 address bits, two extra output stages.
// Define SYNC_SP_RAM_PARITY_EN to also exercise the parity error path.
module tb_sync_sp_ram_be_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        wrEn = 1'b0;
   logic [4:0]  addr = '0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic        gnt, rdValid, addrErr, parErr;
   logic [31:0] rdData;

   int nCompared   = 0;
   int nMismatched = 0;

   always #5 clk = ~clk;

   sync_sp_ram_be_pipe #(
      .ADDR_WIDTH (5),
      .DATA_DEPTH (16),
      .DATA_WIDTH (32),
      .OUT_REGS   (2),
      .INIT_SWEEP (1)
   ) dut (
      .Clk_CI     (clk),
      .Rst_RI     (rst),
      .Req_SI     (req),
      .WrEn_SI    (wrEn),
      .Addr_DI    (addr),
      .ByteEn_DI  (be),
      .WrData_DI  (wdata),
      .Gnt_SO     (gnt),
      .RdValid_SO (rdValid),
      .RdData_DO  (rdData),
      .AddrErr_SO (addrErr),
      .ParErr_SO  (parErr)
   );

   // Stimulus: one granted write; reports the write address-error flag one cycle later.
   task automatic doWrite(input logic [4:0] a, input logic [3:0] b, input logic [31:0] d,
                          output logic g, output logic ae);
      @(negedge clk);
      req = 1'b1; wrEn = 1'b1; addr = a; be = b; wdata = d;
      #1 g = gnt;
      @(negedge clk);
      req = 1'b0; wrEn = 1'b0; be = '0;
      ae = addrErr;
   endtask

   // Stimulus: one read; waits (bounded) for the valid pulse and reports its latency.
   task automatic doRead(input logic [4:0] a, output logic [31:0] d, output logic ae,
                         output logic pe, output int lat);
      @(negedge clk);
      req = 1'b1; wrEn = 1'b0; addr = a; be = '0;
      @(negedge clk);
      req = 1'b0;
      lat = 1;
      while (!rdValid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      if (!rdValid) lat = -1;
      d = rdData; ae = addrErr; pe = parErr;
   endtask

   task automatic test_reset;
      int zeros;
      rst = 1'b1; req = 1'b1; wrEn = 1'b0; addr = '0;
      @(negedge clk); @(negedge clk);
      #1;
      nCompared += 5;
      if (gnt !== 1'b0)      begin nMismatched++; $display("[TB] FAIL reset_gnt: got %b expected 0", gnt); end
      if (rdValid !== 1'b0)  begin nMismatched++; $display("[TB] FAIL reset_rdvalid: got %b expected 0", rdValid); end
      if (rdData !== 32'h0)  begin nMismatched++; $display("[TB] FAIL reset_rddata: got %h expected 00000000", rdData); end
      if (addrErr !== 1'b0)  begin nMismatched++; $display("[TB] FAIL reset_addrerr: got %b expected 0", addrErr); end
      if (parErr !== 1'b0)   begin nMismatched++; $display("[TB] FAIL reset_parerr: got %b expected 0", parErr); end
      rst = 1'b0;
      zeros = 0;
      while (gnt !== 1'b1 && zeros < 100) begin
         zeros++;
         @(negedge clk);
         #1;
      end
      req = 1'b0;
      nCompared++;
      if (zeros !== 16) begin nMismatched++; $display("[TB] FAIL sweep_len: got %0d expected 16 cycles", zeros); end
   endtask

   task automatic test_sweep_zero;
      logic [31:0] d; logic ae, pe; int lat;
      for (int a = 0; a < 16; a++) begin
         doRead(5'(a), d, ae, pe, lat);
         nCompared += 2;
         if (lat !== 3)      begin nMismatched++; $display("[TB] FAIL zero_lat[%0d]: got %0d expected 3", a, lat); end
         if (d !== 32'h0)    begin nMismatched++; $display("[TB] FAIL zero_data[%0d]: got %h expected 00000000", a, d); end
      end
   endtask

   task automatic test_byte_enable;
      logic [31:0] d; logic ae, pe, g; int lat;
      doWrite(5'd5, 4'hF, 32'hDEADBEEF, g, ae);
      nCompared += 2;
      if (g !== 1'b1)  begin nMismatched++; $display("[TB] FAIL wr_gnt: got %b expected 1", g); end
      if (ae !== 1'b0) begin nMismatched++; $display("[TB] FAIL wr_addrerr: got %b expected 0", ae); end
      doWrite(5'd5, 4'b0101, 32'h11223344, g, ae);
      doRead(5'd5, d, ae, pe, lat);
      nCompared += 3;
      if (d !== 32'hDE22BE44) begin nMismatched++; $display("[TB] FAIL be_merge: got %h expected de22be44", d); end
      if (ae !== 1'b0)        begin nMismatched++; $display("[TB] FAIL be_rd_addrerr: got %b expected 0", ae); end
      if (pe !== 1'b0)        begin nMismatched++; $display("[TB] FAIL be_rd_parerr: got %b expected 0", pe); end
      doWrite(5'd5, 4'b0000, 32'hFFFFFFFF, g, ae);
      doRead(5'd5, d, ae, pe, lat);
      nCompared++;
      if (d !== 32'hDE22BE44) begin nMismatched++; $display("[TB] FAIL be_noop: got %h expected de22be44", d); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] vals [3];
      logic g, ae, expValid;
      vals[0] = 32'h00000111; vals[1] = 32'h00000222; vals[2] = 32'h00000333;
      for (int i = 0; i < 3; i++) doWrite(5'(i), 4'hF, vals[i], g, ae);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c < 3) begin req = 1'b1; wrEn = 1'b0; addr = 5'(c); end
         else req = 1'b0;
         #1;
         expValid = (c >= 3 && c <= 5);
         nCompared++;
         if (rdValid !== expValid) begin nMismatched++; $display("[TB] FAIL b2b_valid[c%0d]: got %b expected %b", c, rdValid, expValid); end
         nCompared++;
         if (c < 3) begin
            if (rdData !== 32'hDE22BE44) begin nMismatched++; $display("[TB] FAIL b2b_hold_pre[c%0d]: got %h expected de22be44", c, rdData); end
         end else if (c <= 5) begin
            if (rdData !== vals[c-3]) begin nMismatched++; $display("[TB] FAIL b2b_data[c%0d]: got %h expected %h", c, rdData, vals[c-3]); end
         end else begin
            if (rdData !== 32'h00000333) begin nMismatched++; $display("[TB] FAIL b2b_hold_post[c%0d]: got %h expected 00000333", c, rdData); end
         end
      end
   endtask

   task automatic test_addr_err;
      logic [31:0] d; logic ae, pe, g; int lat;
      doWrite(5'd10, 4'hF, 32'hCAFEF00D, g, ae);
      doWrite(5'd26, 4'hF, 32'h12345678, g, ae);
      nCompared += 2;
      if (g !== 1'b1)  begin nMismatched++; $display("[TB] FAIL oor_wr_gnt: got %b expected 1", g); end
      if (ae !== 1'b1) begin nMismatched++; $display("[TB] FAIL oor_wr_addrerr: got %b expected 1", ae); end
      doRead(5'd26, d, ae, pe, lat);
      nCompared += 3;
      if (lat !== 3)   begin nMismatched++; $display("[TB] FAIL oor_rd_lat: got %0d expected 3", lat); end
      if (d !== 32'h0) begin nMismatched++; $display("[TB] FAIL oor_rd_data: got %h expected 00000000", d); end
      if (ae !== 1'b1) begin nMismatched++; $display("[TB] FAIL oor_rd_addrerr: got %b expected 1", ae); end
      doRead(5'd10, d, ae, pe, lat);
      nCompared += 2;
      if (d !== 32'hCAFEF00D) begin nMismatched++; $display("[TB] FAIL oor_alias: got %h expected cafef00d", d); end
      if (ae !== 1'b0)        begin nMismatched++; $display("[TB] FAIL oor_alias_addrerr: got %b expected 0", ae); end
      doRead(5'd5, d, ae, pe, lat);
      nCompared++;
      if (d !== 32'hDE22BE44) begin nMismatched++; $display("[TB] FAIL oor_other: got %h expected de22be44", d); end
      doRead(5'd31, d, ae, pe, lat);
      nCompared++;
      if (ae !== 1'b1) begin nMismatched++; $display("[TB] FAIL oor_top_addrerr: got %b expected 1", ae); end
   endtask

   task automatic test_reset_pending;
      logic [31:0] d; logic ae, pe; int lat, zeros, seen;
      seen = 0;
      @(negedge clk);
      req = 1'b1; wrEn = 1'b0; addr = 5'd10;
      @(negedge clk);
      req = 1'b0; rst = 1'b1;
      if (rdValid) seen++;
      @(negedge clk);
      rst = 1'b0; req = 1'b1; addr = 5'd0;
      #1;
      nCompared++;
      if (rdData !== 32'h0) begin nMismatched++; $display("[TB] FAIL rstp_rddata: got %h expected 00000000", rdData); end
      zeros = 0;
      while (gnt !== 1'b1 && zeros < 100) begin
         zeros++;
         if (rdValid) seen++;
         @(negedge clk);
         #1;
      end
      req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rdValid) seen++;
      end
      nCompared += 2;
      if (seen !== 0)   begin nMismatched++; $display("[TB] FAIL rstp_lost: got %0d valid pulses expected 0", seen); end
      if (zeros !== 16) begin nMismatched++; $display("[TB] FAIL rstp_sweep: got %0d expected 16 cycles", zeros); end
      doRead(5'd10, d, ae, pe, lat);
      nCompared++;
      if (d !== 32'h0) begin nMismatched++; $display("[TB] FAIL rstp_cleared: got %h expected 00000000", d); end
   endtask

   task automatic test_parity;
      logic [31:0] d; logic ae, pe, g; int lat;
      doWrite(5'd3, 4'hF, 32'h0F0F0F0F, g, ae);
`ifdef SYNC_SP_RAM_PARITY_EN
      dut.mem_q[3] = dut.mem_q[3] ^ 32'h00000001;
      doRead(5'd3, d, ae, pe, lat);
      nCompared += 2;
      if (pe !== 1'b1)        begin nMismatched++; $display("[TB] FAIL par_flip: got %b expected 1", pe); end
      if (d !== 32'h0F0F0F0E) begin nMismatched++; $display("[TB] FAIL par_flip_data: got %h expected 0f0f0f0e", d); end
`else
      doRead(5'd3, d, ae, pe, lat);
      nCompared += 2;
      if (pe !== 1'b0)        begin nMismatched++; $display("[TB] FAIL par_off: got %b expected 0", pe); end
      if (d !== 32'h0F0F0F0F) begin nMismatched++; $display("[TB] FAIL par_off_data: got %h expected 0f0f0f0f", d); end
`endif
      doRead(5'd4, d, ae, pe, lat);
      nCompared++;
      if (pe !== 1'b0) begin nMismatched++; $display("[TB] FAIL par_clean: got %b expected 0", pe); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_sweep_zero();
      test_byte_enable();
      test_back_to_back();
      test_addr_err();
      test_reset_pending();
      test_parity();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
